// File: rtl/note_playback_sequencer.sv
// Note/rest event player: queues duration-coded events in a small FIFO and replays
// each tone for its exact length in sample strobes at the configured tempo.
module note_playback_sequencer #(
  parameter int unsigned BPM            = 60,
  parameter int unsigned SAMPLE_RATE    = 17000,
  parameter int unsigned CLK_PER_SAMPLE = 5882,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       new_note_ready,
  input  logic [5:0] new_note_tone,
  input  logic       eighth_note,
  input  logic       quarter_note,
  input  logic       half_note,
  input  logic       whole_note,
  input  logic       eighth_rest,
  input  logic       quarter_rest,
  input  logic       half_rest,
  input  logic       whole_rest,
  output logic [5:0] note_index,
  output logic       note_index_ready,
  output logic       playing,
  output logic       fifo_full,
  output logic       overflow,
  output logic       bad_event
);

  localparam int unsigned Q_SAMP = SAMPLE_RATE * 60 / BPM;
  localparam int unsigned E_SAMP = Q_SAMP >> 1;
  localparam int unsigned H_SAMP = Q_SAMP << 1;
  localparam int unsigned W_SAMP = Q_SAMP << 2;
  localparam int unsigned RW     = $clog2(W_SAMP + 1);
  localparam int unsigned CW     = $clog2(CLK_PER_SAMPLE);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   smp_cnt_q, smp_cnt_d;
  logic            tick;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      head, wr_entry;
  logic [7:0]      ev_q, ev_d;
  logic            empty, full, pop, wr_en;
  logic [7:0]      flags;
  logic            onehot, is_rest;
  logic [1:0]      cls;
  logic [5:0]      tone_q, tone_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [5:0]      note_index_q, note_index_d;
  logic            ready_q, ready_d;
  logic            playing_q, playing_d;
  logic            overflow_q, overflow_d;
  logic            bad_q, bad_d;

  // Sample strobe generator, free-running in every state
  assign tick      = (smp_cnt_q == CW'(CLK_PER_SAMPLE - 1));
  assign smp_cnt_d = tick ? '0 : smp_cnt_q + 1'b1;

  // Event decode: exactly one duration flag is required
  assign flags   = {whole_rest, half_rest, quarter_rest, eighth_rest,
                    whole_note, half_note, quarter_note, eighth_note};
  assign onehot  = $onehot(flags);
  assign is_rest = |flags[7:4];

  always_comb begin
    cls = 2'd3;
    if (flags[0] | flags[4])      cls = 2'd0;
    else if (flags[1] | flags[5]) cls = 2'd1;
    else if (flags[2] | flags[6]) cls = 2'd2;
  end

  assign wr_entry = {(is_rest ? 6'd0 : new_note_tone), cls};

  // FIFO: pointers carry one extra wrap bit to tell full from empty
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_en = new_note_ready & onehot & (~full | pop);

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  assign overflow_d = overflow_q | (new_note_ready & onehot & full & ~pop);
  assign bad_d      = bad_q | (new_note_ready & ~onehot);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: the final strobe of an event pops the successor in the same cycle
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = PLAY;
      PLAY: begin
        if (tick && rem_q == RW'(1)) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ev_d         = pop ? head : ev_q;
    tone_d       = tone_q;
    rem_d        = rem_q;
    note_index_d = note_index_q;
    playing_d    = playing_q;
    ready_d      = tick;
    if (tick) begin
      note_index_d = (state_q == PLAY) ? tone_q : '0;
      playing_d    = (state_q == PLAY);
    end
    if (state_q == LOAD) begin
      tone_d = ev_q[7:2];
      case (ev_q[1:0])
        2'd0:    rem_d = RW'(E_SAMP);
        2'd1:    rem_d = RW'(Q_SAMP);
        2'd2:    rem_d = RW'(H_SAMP);
        default: rem_d = RW'(W_SAMP);
      endcase
    end else if (state_q == PLAY && tick) begin
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      smp_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ev_q         <= '0;
      tone_q       <= '0;
      rem_q        <= '0;
      note_index_q <= '0;
      ready_q      <= 1'b0;
      playing_q    <= 1'b0;
      overflow_q   <= 1'b0;
      bad_q        <= 1'b0;
    end else begin
      smp_cnt_q    <= smp_cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      ev_q         <= ev_d;
      tone_q       <= tone_d;
      rem_q        <= rem_d;
      note_index_q <= note_index_d;
      ready_q      <= ready_d;
      playing_q    <= playing_d;
      overflow_q   <= overflow_d;
      bad_q        <= bad_d;
    end
  end

  assign note_index       = note_index_q;
  assign note_index_ready = ready_q;
  assign playing          = playing_q;
  assign fifo_full        = full;
  assign overflow         = overflow_q;
  assign bad_event        = bad_q;

endmodule

// File: tb/tb_note_playback_sequencer.sv
// Directed bench for note_playback_sequencer with small timing parameters
// (4 clocks per strobe; eighth/quarter/half/whole = 8/16/32/64 strobes).
module tb_note_playback_sequencer;

  localparam logic [7:0] EN = 8'h01, QN = 8'h02, HN = 8'h04, WN = 8'h08;
  localparam logic [7:0] HR = 8'h40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       nn_ready = 1'b0;
  logic [5:0] nn_tone = '0;
  logic [7:0] fl = '0;
  logic [5:0] note_index;
  logic       note_index_ready, playing, fifo_full, overflow, bad_event;

  int unsigned n_asserts = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  note_playback_sequencer #(
    .BPM(60),
    .SAMPLE_RATE(16),
    .CLK_PER_SAMPLE(4),
    .FIFO_DEPTH(8)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .new_note_ready(nn_ready),
    .new_note_tone(nn_tone),
    .eighth_note(fl[0]),
    .quarter_note(fl[1]),
    .half_note(fl[2]),
    .whole_note(fl[3]),
    .eighth_rest(fl[4]),
    .quarter_rest(fl[5]),
    .half_rest(fl[6]),
    .whole_rest(fl[7]),
    .note_index(note_index),
    .note_index_ready(note_index_ready),
    .playing(playing),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .bad_event(bad_event)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] tone, input logic [7:0] flags);
    @(negedge clk);
    nn_ready = 1'b1;
    nn_tone  = tone;
    fl       = flags;
  endtask

  task automatic idle_in();
    @(negedge clk);
    nn_ready = 1'b0;
    nn_tone  = '0;
    fl       = '0;
  endtask

  task automatic next_strobe(output logic [5:0] nt, output logic pl);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      if (note_index_ready) got = 1'b1;
    end
    check("strobe_timeout", {31'd0, got}, 32'd1);
    nt = note_index;
    pl = playing;
  endtask

  task automatic expect_run(input string tag, input logic [5:0] tone, input int n, input logic pl_exp);
    logic [5:0] nt;
    logic       pl;
    for (int i = 0; i < n; i++) begin
      next_strobe(nt, pl);
      check({tag, "_note"}, {26'd0, nt}, {26'd0, tone});
      check({tag, "_playing"}, {31'd0, pl}, {31'd0, pl_exp});
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_note", {26'd0, note_index}, 32'd0);
    check("rst_ready", {31'd0, note_index_ready}, 32'd0);
    check("rst_flags", {28'd0, playing, fifo_full, overflow, bad_event}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle strobe cadence: first pulse exactly 4 cycles after release
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("first_strobe", {31'd0, note_index_ready}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("idle_note", {26'd0, note_index}, 32'd0);
    check("idle_playing", {31'd0, playing}, 32'd0);
    expect_run("idle", 6'd0, 3, 1'b0);

    // Single quarter note
    drive(6'd12, QN);
    idle_in();
    expect_run("q12", 6'd12, 16, 1'b1);
    expect_run("q12_after", 6'd0, 2, 1'b0);

    // Back-to-back eighth / half rest / whole, no gaps
    drive(6'd5, EN);
    drive(6'd9, HR);
    drive(6'd33, WN);
    idle_in();
    expect_run("e5", 6'd5, 8, 1'b1);
    expect_run("hr", 6'd0, 32, 1'b1);
    expect_run("w33", 6'd33, 64, 1'b1);
    expect_run("seq_after", 6'd0, 1, 1'b0);
    check("no_overflow_yet", {31'd0, overflow}, 32'd0);

    // Overflow: ten events while the first plays, tenth dropped
    drive(6'd1, EN);
    idle_in();
    expect_run("ov_first", 6'd1, 1, 1'b1);
    for (int t = 2; t <= 10; t++) drive(6'(t), EN);
    idle_in();
    check("fifo_full", {31'd0, fifo_full}, 32'd1);
    check("overflow", {31'd0, overflow}, 32'd1);
    expect_run("ov_t1", 6'd1, 5, 1'b1);
    for (int t = 2; t <= 9; t++) expect_run("ov_tn", 6'(t), 8, 1'b1);
    expect_run("ov_after", 6'd0, 2, 1'b0);
    check("fifo_drained", {31'd0, fifo_full}, 32'd0);
    check("bad_clear", {31'd0, bad_event}, 32'd0);

    // Malformed events: two flags, then no flags
    drive(6'd7, QN | HN);
    drive(6'd8, 8'h00);
    idle_in();
    check("bad_event", {31'd0, bad_event}, 32'd1);
    expect_run("bad_silent", 6'd0, 4, 1'b0);

    // Reset in the middle of a whole note with one event still queued
    drive(6'd40, WN);
    idle_in();
    expect_run("w40", 6'd40, 10, 1'b1);
    drive(6'd50, QN);
    idle_in();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_note", {26'd0, note_index}, 32'd0);
    check("mid_rst_flags", {27'd0, note_index_ready, playing, fifo_full, overflow, bad_event}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_strobe", {31'd0, note_index_ready}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("post_rst_note", {26'd0, note_index}, 32'd0);
    expect_run("flushed", 6'd0, 6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
